// File: rtl/xbus_master_port.sv
// Master-side adapter: turns one 8/16/32-bit core access into a run of
// little-endian byte transfers on the shared arbitrated byte bus.
module xbus_master_port #(
    parameter int MASTER_ID = 0,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_in,
    input  logic              cpu_we_in,
    input  logic [1:0]        cpu_size_in,
    input  logic              cpu_unsigned_in,
    input  logic [ADDR_W-1:0] cpu_addr_in,
    input  logic [31:0]       cpu_wdata_in,
    output logic              cpu_ready_out,
    output logic              cpu_done_out,
    output logic              cpu_err_out,
    output logic [31:0]       cpu_rdata_out,
    output logic              hold_out,
    output logic              bus_req_out,
    input  logic [4:0]        bus_master_id_in,
    output logic              bus_rw_out,
    output logic [ADDR_W-1:0] bus_addr_out,
    output logic [7:0]        bus_wdata_out,
    input  logic [7:0]        bus_rdata_in
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              grant, last_byte, bad_access;

    assign grant      = (bus_master_id_in == 5'(MASTER_ID));
    assign last_byte  = ({1'b0, cnt_q} == nbytes_q - 3'd1);
    assign bad_access = (cpu_size_in == 2'd3)
                     || (cpu_size_in == 2'd1 && cpu_addr_in[0])
                     || (cpu_size_in == 2'd2 && cpu_addr_in[1:0] != 2'b00);

    function automatic logic [31:0] extend(input logic [31:0] b, input logic [1:0] sz,
                                           input logic zext);
        case (sz)
            2'd0:    extend = zext ? {24'h0, b[7:0]}  : {{24{b[7]}}, b[7:0]};
            2'd1:    extend = zext ? {16'h0, b[15:0]} : {{16{b[15]}}, b[15:0]};
            default: extend = b;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        nbytes_d = nbytes_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_in) begin
                    we_d     = cpu_we_in;
                    size_d   = cpu_size_in;
                    uns_d    = cpu_unsigned_in;
                    addr_d   = cpu_addr_in;
                    wdata_d  = cpu_wdata_in;
                    nbytes_d = (cpu_size_in == 2'd0) ? 3'd1 : (cpu_size_in == 2'd1) ? 3'd2 : 3'd4;
                    cnt_d    = 2'd0;
                    buf_d    = 32'h0;
                    rdata_d  = 32'h0;
                    state_d  = bad_access ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                // Without grant nothing moves; the same byte is retried next cycle.
                if (grant) begin
                    if (!we_q) buf_d[{cnt_q, 3'b000} +: 8] = bus_rdata_in;
                    cnt_d = cnt_q + 2'd1;
                    if (last_byte) begin
                        state_d = S_DONE;
                        rdata_d = we_q ? 32'h0 : extend(buf_d, size_q, uns_q);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            nbytes_q <= 3'd0;
            cnt_q    <= 2'd0;
            buf_q    <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            nbytes_q <= nbytes_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cpu_ready_out = (state_q == S_IDLE);
    assign hold_out      = (state_q != S_IDLE);
    assign cpu_done_out  = (state_q == S_DONE) || (state_q == S_ERR);
    assign cpu_err_out   = (state_q == S_ERR);
    assign cpu_rdata_out = rdata_q;
    assign bus_req_out   = (state_q == S_REQ);
    assign bus_rw_out    = bus_req_out && we_q;
    assign bus_addr_out  = bus_req_out ? addr_q + ADDR_W'(cnt_q) : '0;
    assign bus_wdata_out = (bus_req_out && we_q) ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h0;
endmodule

// File: tb/tb_xbus_master_port.sv
// Bench for xbus_master_port: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_xbus_master_port;
    localparam int MID = 3;
    localparam logic [4:0] NOG = 5'd31;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_in, cpu_we_in, cpu_unsigned_in;
    logic [1:0]  cpu_size_in;
    logic [31:0] cpu_addr_in, cpu_wdata_in;
    logic        cpu_ready_out, cpu_done_out, cpu_err_out, hold_out;
    logic [31:0] cpu_rdata_out;
    logic        bus_req_out, bus_rw_out;
    logic [4:0]  bus_master_id_in;
    logic [31:0] bus_addr_out;
    logic [7:0]  bus_wdata_out, bus_rdata_in;

    always #5 clk = ~clk;

    xbus_master_port #(.MASTER_ID(MID), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_in(cpu_req_in), .cpu_we_in(cpu_we_in), .cpu_size_in(cpu_size_in),
        .cpu_unsigned_in(cpu_unsigned_in), .cpu_addr_in(cpu_addr_in),
        .cpu_wdata_in(cpu_wdata_in), .cpu_ready_out(cpu_ready_out),
        .cpu_done_out(cpu_done_out), .cpu_err_out(cpu_err_out),
        .cpu_rdata_out(cpu_rdata_out), .hold_out(hold_out),
        .bus_req_out(bus_req_out), .bus_master_id_in(bus_master_id_in),
        .bus_rw_out(bus_rw_out), .bus_addr_out(bus_addr_out),
        .bus_wdata_out(bus_wdata_out), .bus_rdata_in(bus_rdata_in)
    );

    int tests = 0;
    int fails = 0;

    // Model: one outstanding access, tracked as "on the bus" or "finishing".
    bit          m_on_bus = 0, m_finish = 0, m_fin_err = 0;
    bit          m_we, m_uns;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata = 0;
    int          m_nbytes, m_idx;
    logic [7:0]  m_bytes[4];

    bit          obs_ready, obs_hold, obs_req, obs_done, obs_err;
    logic [31:0] obs_addr, obs_rdata;
    logic [7:0]  obs_wdata;
    logic [31:0] log_addr[4];
    logic [7:0]  log_wd[4];
    logic [7:0]  rbytes[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_cycle();
        bit idle;
        logic [31:0] ea;
        logic [31:0] ew;
        idle = !m_on_bus && !m_finish;
        ea = m_addr + 32'(m_idx);
        ew = (m_wdata >> (8 * m_idx)) & 32'hFF;
        chk("ready", {31'b0, cpu_ready_out}, {31'b0, idle});
        chk("hold", {31'b0, hold_out}, {31'b0, !idle});
        chk("bus_req", {31'b0, bus_req_out}, {31'b0, m_on_bus});
        chk("bus_rw", {31'b0, bus_rw_out}, {31'b0, m_on_bus && m_we});
        chk("bus_addr", bus_addr_out, m_on_bus ? ea : 32'h0);
        chk("bus_wdata", {24'h0, bus_wdata_out}, (m_on_bus && m_we) ? ew : 32'h0);
        chk("done", {31'b0, cpu_done_out}, {31'b0, m_finish});
        chk("err", {31'b0, cpu_err_out}, {31'b0, m_finish && m_fin_err});
        if (m_finish) chk("rdata", cpu_rdata_out, m_rdata);
    endtask

    task automatic model_update();
        longint v;
        if (rst) begin
            m_on_bus = 0; m_finish = 0; m_fin_err = 0; m_rdata = 0;
        end else if (m_finish) begin
            m_finish = 0;
        end else if (m_on_bus) begin
            if (bus_master_id_in == 5'(MID)) begin
                if (!m_we) m_bytes[m_idx] = bus_rdata_in;
                m_idx++;
                if (m_idx == m_nbytes) begin
                    m_on_bus = 0; m_finish = 1; m_fin_err = 0;
                    if (m_we) m_rdata = 0;
                    else begin
                        v = 0;
                        for (int i = 0; i < m_nbytes; i++) v += longint'(m_bytes[i]) << (8 * i);
                        if (!m_uns && v >= (64'sd1 <<< (8 * m_nbytes - 1)))
                            v -= (64'sd1 <<< (8 * m_nbytes));
                        m_rdata = v[31:0];
                    end
                end
            end
        end else if (cpu_req_in) begin
            m_we = cpu_we_in; m_size = cpu_size_in; m_uns = cpu_unsigned_in;
            m_addr = cpu_addr_in; m_wdata = cpu_wdata_in; m_idx = 0; m_rdata = 0;
            if (m_size == 2'd3 || (m_addr & ((32'd1 << m_size) - 32'd1)) != 0) begin
                m_finish = 1; m_fin_err = 1;
            end else begin
                m_on_bus = 1; m_nbytes = 1 << m_size;
            end
        end
    endtask

    task automatic step(input logic r, input logic req, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] id, input logic [7:0] rb);
        @(negedge clk);
        rst = r; cpu_req_in = req; cpu_we_in = we; cpu_size_in = sz;
        cpu_unsigned_in = uns; cpu_addr_in = a; cpu_wdata_in = wd;
        bus_master_id_in = id; bus_rdata_in = rb;
        #1;
        compare_cycle();
        obs_ready = cpu_ready_out; obs_hold = hold_out; obs_req = bus_req_out;
        obs_done = cpu_done_out; obs_err = cpu_err_out; obs_addr = bus_addr_out;
        obs_rdata = cpu_rdata_out; obs_wdata = bus_wdata_out;
        @(posedge clk);
        model_update();
    endtask

    // One access from accept to done; grant withheld 'gap' cycles after byte 0,
    // reset asserted on the cycle carrying byte index rst_at (-1: never).
    task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input int gap,
                          input int rst_at, output bit got_done, output logic [31:0] rd,
                          output bit er, output int cyc, output int nreq, output int npause);
        int k, withheld;
        bit g, r;
        got_done = 0; er = 0; rd = 0; cyc = 1; nreq = 0; npause = 0; k = 0; withheld = 0;
        step(1'b0, 1'b1, we, sz, uns, a, wd, NOG, 8'h00);
        chk("accept_ready", {31'b0, obs_ready}, 32'd1);
        for (int t = 0; t < 40 && !got_done; t++) begin
            g = !(k == 1 && withheld < gap);
            r = (k == rst_at);
            step(r, 1'b0, we, sz, uns, a, wd, g ? 5'(MID) : NOG, rbytes[k[1:0]]);
            cyc++;
            if (obs_req) nreq++;
            if (r) return;
            if (obs_done) begin
                got_done = 1; rd = obs_rdata; er = obs_err;
            end else if (obs_req && g) begin
                log_addr[k[1:0]] = obs_addr; log_wd[k[1:0]] = obs_wdata; k++;
            end else if (obs_req) begin
                withheld++;
                if (obs_addr == a + 32'd1) npause++;
            end
        end
    endtask

    initial begin
        bit          gd, er;
        logic [31:0] rd, a;
        int          cyc, nreq, np;
        logic [1:0]  sz;
        logic [4:0]  id;

        rst = 1; cpu_req_in = 0; cpu_we_in = 0; cpu_size_in = 0; cpu_unsigned_in = 0;
        cpu_addr_in = 0; cpu_wdata_in = 0; bus_master_id_in = NOG; bus_rdata_in = 0;
        repeat (2) @(posedge clk);
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, NOG, 8'h00);
        chk("rst_ready", {31'b0, obs_ready}, 32'd1);
        chk("rst_rdata", obs_rdata, 32'h0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, NOG, 8'h00);

        rbytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        access(1'b0, 2'd2, 1'b0, 32'h100, 0, 0, -1, gd, rd, er, cyc, nreq, np);
        chk("wl_done", {31'b0, gd}, 32'd1);
        chk("wl_rdata", rd, 32'h4433_2211);
        chk("wl_cycles", cyc, 6);
        chk("wl_addr0", log_addr[0], 32'h100);
        chk("wl_addr3", log_addr[3], 32'h103);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, NOG, 8'h00);
        chk("wl_hold_after", {31'b0, obs_hold}, 32'd0);

        rbytes = '{8'h80, 8'h00, 8'h00, 8'h00};
        access(1'b0, 2'd0, 1'b0, 32'h205, 0, 0, -1, gd, rd, er, cyc, nreq, np);
        chk("bl_signed", rd, 32'hFFFF_FF80);
        access(1'b0, 2'd0, 1'b1, 32'h205, 0, 0, -1, gd, rd, er, cyc, nreq, np);
        chk("bl_unsigned", rd, 32'h0000_0080);

        access(1'b1, 2'd1, 1'b0, 32'h10, 32'h0000_BEEF, 3, -1, gd, rd, er, cyc, nreq, np);
        chk("hs_done", {31'b0, gd}, 32'd1);
        chk("hs_byte0", {24'h0, log_wd[0]}, 32'hEF);
        chk("hs_byte1", {24'h0, log_wd[1]}, 32'hBE);
        chk("hs_addr1", log_addr[1], 32'h11);
        chk("hs_pause", np, 3);
        chk("hs_rdata", rd, 32'h0);

        access(1'b0, 2'd2, 1'b0, 32'h102, 0, 0, -1, gd, rd, er, cyc, nreq, np);
        chk("mis_err", {31'b0, er}, 32'd1);
        chk("mis_cycles", cyc, 2);
        chk("mis_noreq", nreq, 0);
        access(1'b0, 2'd3, 1'b0, 32'h100, 0, 0, -1, gd, rd, er, cyc, nreq, np);
        chk("sz3_err", {31'b0, er}, 32'd1);
        chk("sz3_rdata", rd, 32'h0);

        access(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFE_F00D, 0, 2, gd, rd, er, cyc, nreq, np);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 5'(MID), 8'h00);
        chk("abort_req", {31'b0, obs_req}, 32'd0);
        chk("abort_done", {31'b0, obs_done}, 32'd0);
        chk("abort_ready", {31'b0, obs_ready}, 32'd1);
        rbytes = '{8'h34, 8'h12, 8'h00, 8'h00};
        access(1'b0, 2'd1, 1'b1, 32'h40, 0, 0, -1, gd, rd, er, cyc, nreq, np);
        chk("after_abort_addr", log_addr[0], 32'h40);
        chk("after_abort_rdata", rd, 32'h1234);

        access(1'b0, 2'd1, 1'b0, 32'hFFFF_FFFE, 0, 0, -1, gd, rd, er, cyc, nreq, np);
        chk("wrap_h0", log_addr[0], 32'hFFFF_FFFE);
        chk("wrap_h1", log_addr[1], 32'hFFFF_FFFF);
        access(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 0, 0, -1, gd, rd, er, cyc, nreq, np);
        chk("wrap_w3", log_addr[3], 32'hFFFF_FFFF);
        chk("b2b_done", {31'b0, gd}, 32'd1);

        for (int c = 0; c < 4000; c++) begin
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            id = ($urandom_range(0, 9) < 7) ? 5'(MID) : 5'($urandom_range(0, 31));
            if (id == 5'(MID) && $urandom_range(0, 9) >= 7) id = NOG;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, 1'($urandom),
                 sz, 1'($urandom), a, $urandom, id, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/xbus_master_port.md
Name: xbus_master_port

Overview:
- Master-side adapter between a core load/store port and the shared byte-wide simulation bus arbiter.
- Accepts one 8/16/32-bit access at a time and raises its request bit into the arbiter's request vector.
- Waits for grant, then performs the access as consecutive little-endian byte transfers.
- Returns the assembled, optionally sign-extended load data with a one-cycle done pulse. Drives hold_out so the core stalls while the access is outstanding.

Parameters:
- MASTER_ID, 0, this port's index in the arbiter request vector; grant means bus_master_id_in == MASTER_ID (0..30; 31 is reserved as "no master").
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_req_in  in  1  access request; sampled only when cpu_ready_out=1
- cpu_we_in  in  1  1=store, 0=load
- cpu_size_in  in  2  0=byte, 1=half, 2=word, 3=illegal
- cpu_unsigned_in  in  1  load zero-extend (1) or sign-extend (0)
- cpu_addr_in  in  ADDR_W  byte address
- cpu_wdata_in  in  32  store data, LSB-aligned
- cpu_ready_out  out  1  port idle and can accept a request
- cpu_done_out  out  1  one-cycle completion pulse
- cpu_err_out  out  1  valid with cpu_done_out; access was misaligned or illegal
- cpu_rdata_out  out  32  load result; valid with cpu_done_out, held until next accept
- hold_out  out  1  stall core; 1 in every state except IDLE
- bus_req_out  out  1  request bit into arbiter vector
- bus_master_id_in  in  5  arbiter's current master id
- bus_rw_out  out  1  1=write, 0=read; 0 when not in REQ
- bus_addr_out  out  ADDR_W  current byte address; 0 when not in REQ
- bus_wdata_out  out  8  current write byte; 0 when not in REQ or when reading
- bus_rdata_in  in  8  read byte returned combinationally by the bus

Behaviour:
- States: IDLE, REQ, DONE, ERR. Reset puts the FSM in IDLE and clears the byte counter and all latches. Reset values: cpu_ready_out=1, hold_out=0, bus_req_out=0, cpu_done_out=0, cpu_err_out=0, cpu_rdata_out=0, bus_* outputs=0.
- Reset asserted mid-access aborts the access at that edge. bus_req_out is 0 from the following cycle. No done pulse is produced for the aborted access.
- IDLE, cpu_req_in=1: latch we, size, unsigned, addr, wdata; set nbytes to 1, 2 or 4; clear cnt.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=3: go to ERR.
  - Otherwise: go to REQ.
- REQ:
  - Outputs: bus_req_out=1; bus_addr_out=addr+cnt (wraps modulo 2^ADDR_W); bus_rw_out=we; bus_wdata_out=wdata byte[cnt] when writing.
  - grant = (bus_master_id_in == MASTER_ID). On each edge with grant=1 the byte completes: on a read, capture bus_rdata_in into byte lane cnt; then cnt++.
  - Edge with grant=1 and cnt==nbytes-1: go to DONE.
  - Edge with grant=0: no change; cnt holds and the request stays asserted. Losing grant mid-access simply pauses the transfer; it resumes at the same byte.
- DONE, one cycle:
  - cpu_done_out=1, bus_req_out=0.
  - cpu_rdata_out = assembled bytes, upper bits zero- or sign-extended from bit 7 or 15 per cpu_unsigned_in; 0 for stores.
  - Next state IDLE.
- ERR, one cycle: cpu_done_out=1, cpu_err_out=1, cpu_rdata_out=0, no bus activity. Next state IDLE.
- cpu_ready_out=1 only in IDLE. A new request may be accepted in the cycle after DONE or ERR.
- Latency with continuous grant: accept edge, then nbytes REQ cycles, then the DONE cycle. A word access therefore takes 6 cycles from accept to done, inclusive.

Test Plan:
- Word load, addr 0x0000_0100, grant held, bus returns 0x11,0x22,0x33,0x44 -> bus_addr_out 0x100..0x103 in 4 consecutive cycles, cpu_rdata_out=0x4433_2211, done pulse 1 cycle, hold_out low the cycle after.
- Byte load signed, addr 0x205, bus returns 0x80 -> rdata 0xFFFF_FF80; repeat unsigned -> 0x0000_0080.
- Half store 0x0000_BEEF to 0x10, grant withheld 3 cycles after byte 0 -> bus_rw_out=1; byte 0xEF at 0x10, then pause with bus_req_out=1 and addr held at 0x11, then 0xBE at 0x11; done after the second granted byte.
- Word load at 0x102 -> ERR: done+err in the cycle after accept, bus_req_out never 1, rdata 0. Repeat with size=3 -> same result.
- Reset asserted during the third byte of a word store -> bus_req_out 0 from the next cycle, no done pulse, cpu_ready_out=1; the next request starts at cnt=0.
- Address 0xFFFF_FFFE half load -> bus_addr_out 0xFFFF_FFFE then 0xFFFF_FFFF. Word load at 0xFFFF_FFFC -> addresses ...FC..FF. Back-to-back requests -> second accepted the cycle after the first done.
